// File: rtl/maze_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : maze_mem_arbiter
// Purpose  : Round-robin arbiter sharing the single-port maze bit memory
//            between the maze-solver controller and the external host port.
//            A solver lock holds off new host grants while a solve runs.
// Options  : ARB_TIMEOUT_EN - adds the sticky host-starvation detector.
// Revision : 1.0 - initial release
// ============================================================================
module maze_mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    // solver port
    input  logic          sol_req,
    input  logic          sol_we,
    input  logic [AW-1:0] sol_addr,
    input  logic [DW-1:0] sol_wdata,
    input  logic          sol_lock,
    output logic          sol_gnt,
    output logic          sol_rvalid,
    output logic [DW-1:0] sol_rdata,
    // host port
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          host_timeout
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_S = 2'd1;
    localparam logic [1:0] c_GNT_H = 2'd2;

    localparam logic c_LAST_HOST = 1'b0;
    localparam logic c_LAST_SOL  = 1'b1;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_last;
    logic       w_host_elig;
    logic       r_sol_rvalid;
    logic       r_host_rvalid;

    // The lock only gates the host's eligibility for a fresh grant.
    assign w_host_elig = host_req & ~sol_lock;

    // State and round-robin history; history tracks whichever grant is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_last  <= c_LAST_HOST;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == c_GNT_S) begin
                r_last <= c_LAST_SOL;
            end else if (w_state_next == c_GNT_H) begin
                r_last <= c_LAST_HOST;
            end
        end
    end

    // Next grant: the requester just served is skipped, ties go to the other one.
    always_comb begin
        w_state_next = c_IDLE;
        case (r_state)
            c_IDLE: begin
                if (sol_req && w_host_elig) begin
                    w_state_next = (r_last == c_LAST_SOL) ? c_GNT_H : c_GNT_S;
                end else if (sol_req) begin
                    w_state_next = c_GNT_S;
                end else if (w_host_elig) begin
                    w_state_next = c_GNT_H;
                end else begin
                    w_state_next = c_IDLE;
                end
            end
            c_GNT_S: w_state_next = w_host_elig ? c_GNT_H : c_IDLE;
            c_GNT_H: w_state_next = sol_req ? c_GNT_S : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Grant strobes and memory mux; the memory bus is quiet when nobody owns it.
    always_comb begin
        sol_gnt   = 1'b0;
        host_gnt  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            c_GNT_S: begin
                sol_gnt   = 1'b1;
                mem_en    = 1'b1;
                mem_we    = sol_we;
                mem_addr  = sol_addr;
                mem_wdata = sol_wdata;
            end
            c_GNT_H: begin
                host_gnt  = 1'b1;
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            default: begin
                sol_gnt  = 1'b0;
                host_gnt = 1'b0;
            end
        endcase
    end

    // Read-valid follows a granted read by one cycle, matching memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sol_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_sol_rvalid  <= sol_gnt & ~sol_we;
            r_host_rvalid <= host_gnt & ~host_we;
        end
    end

    assign sol_rvalid  = r_sol_rvalid;
    assign host_rvalid = r_host_rvalid;
    assign sol_rdata   = r_sol_rvalid  ? mem_rdata : '0;
    assign host_rdata  = r_host_rvalid ? mem_rdata : '0;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [7:0] r_host_wait;
    logic [7:0] w_host_wait_next;
    logic       r_host_timeout;

    // Count consecutive cycles the host waits unserved, saturating at 255.
    always_comb begin
        w_host_wait_next = 8'd0;
        if (host_req && !host_gnt) begin
            w_host_wait_next = (r_host_wait == 8'hFF) ? r_host_wait : r_host_wait + 8'd1;
        end
    end

    // Starvation flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_host_wait    <= 8'd0;
            r_host_timeout <= 1'b0;
        end else begin
            r_host_wait <= w_host_wait_next;
            if (w_host_wait_next >= c_TIMEOUT) begin
                r_host_timeout <= 1'b1;
            end
        end
    end

    assign host_timeout = r_host_timeout;
`else
    assign host_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
